// File: rtl/fft_radix2_iter.sv
// Iterative in-place radix-2 DIT FFT/IFFT with one time-shared butterfly and valid/ready streaming.
// Optional macro FFT_RADIX2_ITER_SCALE_EN: halve every butterfly output (results become DFT/N).
module fft_radix2_iter #(
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16,
    parameter int N          = 8
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_real,
    input  logic signed [DATA_WIDTH-1:0] s_imag,
    input  logic                         inverse,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [DATA_WIDTH-1:0] m_real,
    output logic signed [DATA_WIDTH-1:0] m_imag,
    output logic [$clog2(N)-1:0]         m_index,
    output logic                         m_last,
    output logic                         busy,
    output logic                         ovf
);
    localparam int L  = $clog2(N);
    localparam int KW = L - 1;
    localparam int SW = $clog2(L) + 1;
    localparam int PW = DATA_WIDTH + TW_WIDTH + 1;
    localparam int YW = DATA_WIDTH + 2;
    localparam logic [L-1:0]         LAST_IDX = L'(N - 1);
    localparam logic [KW-1:0]        K_MAX    = {KW{1'b1}};
    localparam logic signed [YW-1:0] SAT_MAX  = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [YW-1:0] SAT_MIN  = {3'b111, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_CALC = 2'd1, ST_OUT = 2'd2} state_t;

    // Elaboration-time cos/sin of 2*pi*j/N via Q30 Taylor series, rounded to Q2.(TW_WIDTH-2).
    function automatic logic signed [TW_WIDTH-1:0] tw_calc_f(input int j, input logic want_sin);
        longint x, x2, term, acc;
        int     jj, n, shift;
        logic   neg;
        jj  = j;
        neg = 1'b0;
        if (4 * j > N) begin
            jj  = N / 2 - j;
            neg = !want_sin;
        end
        x    = (64'sd3373259426 * longint'(2 * jj)) / longint'(N);
        x2   = (x * x) >>> 30;
        term = want_sin ? x : (64'sd1 <<< 30);
        n    = want_sin ? 1 : 0;
        acc  = 64'sd0;
        for (int it = 0; it < 12; it++) begin
            acc  = acc + term;
            term = -((term * x2) >>> 30) / longint'((n + 1) * (n + 2));
            n    = n + 2;
        end
        shift = 30 - (TW_WIDTH - 2);
        acc   = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        if (neg) acc = -acc;
        return TW_WIDTH'(acc);
    endfunction

    function automatic logic [L-1:0] bitrev_f(input logic [L-1:0] v);
        logic [L-1:0] r;
        for (int i = 0; i < L; i++) r[i] = v[L-1-i];
        return r;
    endfunction

    // Returns {saturated, value}.
    function automatic logic [DATA_WIDTH:0] sat_f(input logic signed [YW-1:0] v);
        if (v > SAT_MAX)      return {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        else if (v < SAT_MIN) return {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        else                  return {1'b0, v[DATA_WIDTH-1:0]};
    endfunction

    logic signed [TW_WIDTH-1:0]   w_tw_cos [N/2];
    logic signed [TW_WIDTH-1:0]   w_tw_sin [N/2];
    logic signed [DATA_WIDTH-1:0] r_mem_re [N];
    logic signed [DATA_WIDTH-1:0] r_mem_im [N];

    for (genvar g = 0; g < N / 2; g++) begin : g_tw
        localparam logic signed [TW_WIDTH-1:0] C_COS = tw_calc_f(g, 1'b0);
        localparam logic signed [TW_WIDTH-1:0] C_SIN = tw_calc_f(g, 1'b1);
        assign w_tw_cos[g] = C_COS;
        assign w_tw_sin[g] = C_SIN;
    end

    state_t                       r_state;
    logic [L-1:0]                 r_load_cnt, r_out_cnt;
    logic [SW-1:0]                r_stage;
    logic [KW-1:0]                r_k;
    logic                         r_inv, r_s_ready, r_m_valid, r_m_last, r_busy, r_ovf;
    logic signed [DATA_WIDTH-1:0] r_m_real, r_m_imag;
    logic [L-1:0]                 r_m_index;

    logic [L-1:0]  w_half, w_mask, w_k_ext, w_addr_a, w_addr_b, w_tw_full, w_out_next;
    logic [SW-1:0] w_tw_sh;
    logic [KW-1:0] w_tw_idx;

    // Butterfly operand addresses and twiddle index for the current (stage, k).
    always_comb begin
        w_half     = L'(1'b1) << r_stage;
        w_mask     = w_half - L'(1'b1);
        w_k_ext    = {1'b0, r_k};
        w_addr_a   = ((w_k_ext >> r_stage) << (r_stage + SW'(1))) + (w_k_ext & w_mask);
        w_addr_b   = w_addr_a + w_half;
        w_tw_sh    = SW'(L - 1) - r_stage;
        w_tw_full  = (w_k_ext & w_mask) << w_tw_sh;
        w_tw_idx   = w_tw_full[KW-1:0];
        w_out_next = r_out_cnt + L'(1'b1);
    end

    logic signed [TW_WIDTH-1:0]   w_w_re, w_w_im;
    logic signed [PW-1:0]         w_pr_full, w_pi_full;
    logic signed [YW-1:0]         w_p_re, w_p_im, w_s0_re, w_s0_im, w_s1_re, w_s1_im;
    logic [DATA_WIDTH:0]          w_y0_re, w_y0_im, w_y1_re, w_y1_im;
    logic                         w_ovf_any;

    // Complex multiply, add/subtract at DATA_WIDTH+2 bits, optional halving, saturation.
    always_comb begin
        w_w_re    = w_tw_cos[w_tw_idx];
        w_w_im    = r_inv ? w_tw_sin[w_tw_idx] : -w_tw_sin[w_tw_idx];
        w_pr_full = PW'(w_w_re) * PW'(r_mem_re[w_addr_b]) - PW'(w_w_im) * PW'(r_mem_im[w_addr_b]);
        w_pi_full = PW'(w_w_re) * PW'(r_mem_im[w_addr_b]) + PW'(w_w_im) * PW'(r_mem_re[w_addr_b]);
        w_p_re    = YW'(w_pr_full >>> (TW_WIDTH - 2));
        w_p_im    = YW'(w_pi_full >>> (TW_WIDTH - 2));
`ifdef FFT_RADIX2_ITER_SCALE_EN
        w_s0_re   = (YW'(r_mem_re[w_addr_a]) + w_p_re) >>> 1;
        w_s0_im   = (YW'(r_mem_im[w_addr_a]) + w_p_im) >>> 1;
        w_s1_re   = (YW'(r_mem_re[w_addr_a]) - w_p_re) >>> 1;
        w_s1_im   = (YW'(r_mem_im[w_addr_a]) - w_p_im) >>> 1;
`else
        w_s0_re   = YW'(r_mem_re[w_addr_a]) + w_p_re;
        w_s0_im   = YW'(r_mem_im[w_addr_a]) + w_p_im;
        w_s1_re   = YW'(r_mem_re[w_addr_a]) - w_p_re;
        w_s1_im   = YW'(r_mem_im[w_addr_a]) - w_p_im;
`endif
        w_y0_re   = sat_f(w_s0_re);
        w_y0_im   = sat_f(w_s0_im);
        w_y1_re   = sat_f(w_s1_re);
        w_y1_im   = sat_f(w_s1_im);
        w_ovf_any = w_y0_re[DATA_WIDTH] | w_y0_im[DATA_WIDTH] | w_y1_re[DATA_WIDTH] | w_y1_im[DATA_WIDTH];
    end

    // Frame storage: bit-reversed load, then in-place butterfly writeback.
    always_ff @(posedge clk) begin
        if (r_state == ST_LOAD && s_valid && r_s_ready) begin
            r_mem_re[bitrev_f(r_load_cnt)] <= s_real;
            r_mem_im[bitrev_f(r_load_cnt)] <= s_imag;
        end else if (r_state == ST_CALC) begin
            r_mem_re[w_addr_a] <= w_y0_re[DATA_WIDTH-1:0];
            r_mem_im[w_addr_a] <= w_y0_im[DATA_WIDTH-1:0];
            r_mem_re[w_addr_b] <= w_y1_re[DATA_WIDTH-1:0];
            r_mem_im[w_addr_b] <= w_y1_im[DATA_WIDTH-1:0];
        end
    end

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= ST_LOAD;
            r_load_cnt <= '0;
            r_out_cnt  <= '0;
            r_stage    <= '0;
            r_k        <= '0;
            r_inv      <= 1'b0;
            r_s_ready  <= 1'b1;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_m_index  <= '0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            r_m_real   <= '0;
            r_m_imag   <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (s_valid && r_s_ready) begin
                        if (r_load_cnt == '0) begin
                            r_inv <= inverse;
                            r_ovf <= 1'b0;
                        end
                        if (r_load_cnt == LAST_IDX) begin
                            r_state    <= ST_CALC;
                            r_s_ready  <= 1'b0;
                            r_busy     <= 1'b1;
                            r_load_cnt <= '0;
                            r_stage    <= '0;
                            r_k        <= '0;
                        end else begin
                            r_load_cnt <= r_load_cnt + L'(1'b1);
                        end
                    end
                end
                ST_CALC: begin
                    if (w_ovf_any) r_ovf <= 1'b1;
                    if (r_k == K_MAX) begin
                        r_k <= '0;
                        if (r_stage == SW'(L - 1)) begin
                            // Final butterfly writes N/2-1 and N-1, so entry 0 is already settled.
                            r_state   <= ST_OUT;
                            r_m_valid <= 1'b1;
                            r_out_cnt <= '0;
                            r_m_index <= '0;
                            r_m_last  <= 1'b0;
                            r_m_real  <= r_mem_re[0];
                            r_m_imag  <= r_mem_im[0];
                        end else begin
                            r_stage <= r_stage + SW'(1);
                        end
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        if (r_m_last) begin
                            r_state   <= ST_LOAD;
                            r_m_valid <= 1'b0;
                            r_m_last  <= 1'b0;
                            r_busy    <= 1'b0;
                            r_s_ready <= 1'b1;
                            r_out_cnt <= '0;
                        end else begin
                            r_out_cnt <= w_out_next;
                            r_m_index <= w_out_next;
                            r_m_last  <= (w_out_next == LAST_IDX);
                            r_m_real  <= r_mem_re[w_out_next];
                            r_m_imag  <= r_mem_im[w_out_next];
                        end
                    end
                end
                default: begin
                    r_state   <= ST_LOAD;
                    r_s_ready <= 1'b1;
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign m_index = r_m_index;
    assign m_real  = r_m_real;
    assign m_imag  = r_m_imag;
    assign busy    = r_busy;
    assign ovf     = r_ovf;
endmodule

// File: tb/tb_fft_radix2_iter.sv
// Directed bench for fft_radix2_iter (N=8, default build without per-stage scaling).
module tb_fft_radix2_iter;
    localparam int DW = 16;
    localparam int NP = 8;

    logic                 clk = 1'b0;
    logic                 arst_n;
    logic                 s_valid, s_ready, inverse;
    logic signed [DW-1:0] s_real, s_imag, m_real, m_imag;
    logic                 m_valid, m_ready, m_last, busy, ovf;
    logic [2:0]           m_index;

    int   n_cmp = 0;
    int   n_err = 0;
    int   in_re[NP], in_im[NP], exp_re[NP], exp_im[NP], got_re[NP], got_im[NP];
    logic hold_sv = 1'b0;

    fft_radix2_iter #(.DATA_WIDTH(DW), .TW_WIDTH(16), .N(NP)) dut (
        .clk(clk), .arst_n(arst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag), .inverse(inverse),
        .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
        .m_index(m_index), .m_last(m_last), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_impulse(input int pos, input int amp);
        for (int i = 0; i < NP; i++) begin
            in_re[i] = (i == pos) ? amp : 0;
            in_im[i] = 0;
        end
    endtask

    task automatic set_const(input int v);
        for (int i = 0; i < NP; i++) begin
            in_re[i] = v;
            in_im[i] = 0;
        end
    endtask

    // Later samples carry the opposite mode to show inverse is only taken at the first handshake.
    task automatic load_frame(input logic inv, input logic check_lat, input logic wait_out);
        int t;
        int lat;
        for (int i = 0; i < NP; i++) begin
            s_valid = 1'b1;
            s_real  = DW'(in_re[i]);
            s_imag  = DW'(in_im[i]);
            inverse = (i == 0) ? inv : ~inv;
            t = 0;
            while (!s_ready && t < 100) begin
                tick();
                t++;
            end
            if (!s_ready) check_val("load_timeout", 0, 1);
            tick();
            if (i == 0) check_val("ovf_clear_first", int'(ovf), 0);
        end
        if (hold_sv) begin
            s_real = 16'sd12345;
            s_imag = -16'sd321;
        end else begin
            s_valid = 1'b0;
        end
        if (wait_out) begin
            lat = 0;
            while (!m_valid && lat < 100) begin
                if (hold_sv) check_val("s_ready_calc", int'(s_ready), 0);
                tick();
                lat++;
            end
            if (check_lat) check_val("latency", lat, 12);
        end
        s_valid = 1'b0;
    endtask

    task automatic collect_frame(input logic bp);
        int   exp_idx = 0;
        int   t = 0;
        logic done = 1'b0;
        logic stalled;
        int   sr, si, sx;
        while (!done && t < 300) begin
            m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (m_valid) begin
                if (m_ready) begin
                    check_val("m_index", int'(m_index), exp_idx);
                    check_val("m_last", int'(m_last), int'(exp_idx == NP - 1));
                    if (exp_idx < NP) begin
                        got_re[exp_idx] = m_real;
                        got_im[exp_idx] = m_imag;
                    end
                    if (m_last || exp_idx >= NP) done = 1'b1;
                    exp_idx++;
                end else begin
                    stalled = 1'b1;
                    sr = m_real;
                    si = m_imag;
                    sx = m_index;
                end
            end
            tick();
            t++;
            if (stalled) begin
                check_val("stall_valid", int'(m_valid), 1);
                check_val("stall_real", int'(m_real), sr);
                check_val("stall_imag", int'(m_imag), si);
                check_val("stall_index", int'(m_index), sx);
            end
        end
        if (!done) check_val("out_timeout", 0, 1);
        m_ready = 1'b0;
        check_val("s_ready_after_last", int'(s_ready), 1);
        check_val("busy_after_last", int'(busy), 0);
        check_val("m_valid_after_last", int'(m_valid), 0);
        for (int k = 0; k < NP; k++) begin
            check_val($sformatf("bin%0d_re", k), got_re[k], exp_re[k]);
            check_val($sformatf("bin%0d_im", k), got_im[k], exp_im[k]);
        end
    endtask

    initial begin
        arst_n  = 1'b0;
        s_valid = 1'b0;
        s_real  = '0;
        s_imag  = '0;
        inverse = 1'b0;
        m_ready = 1'b0;
        repeat (3) tick();
        arst_n = 1'b1;
        tick();

        check_val("rst_s_ready", int'(s_ready), 1);
        check_val("rst_m_valid", int'(m_valid), 0);
        check_val("rst_m_last", int'(m_last), 0);
        check_val("rst_m_index", int'(m_index), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_ovf", int'(ovf), 0);
        check_val("rst_m_real", int'(m_real), 0);
        check_val("rst_m_imag", int'(m_imag), 0);

        // Impulse at n=0: flat spectrum, 12-cycle latency.
        set_impulse(0, 1000);
        exp_re = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
        exp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        load_frame(1'b0, 1'b1, 1'b1);
        check_val("busy_calc_done", int'(busy), 1);
        collect_frame(1'b0);
        check_val("impulse_ovf", int'(ovf), 0);

        // DC, with s_valid left high through CALC to show nothing is accepted.
        set_const(100);
        exp_re = '{800, 0, 0, 0, 0, 0, 0, 0};
        exp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        hold_sv = 1'b1;
        load_frame(1'b0, 1'b1, 1'b1);
        hold_sv = 1'b0;
        collect_frame(1'b0);

        // x[1]=1000 forward under random backpressure; twiddle products truncate toward -inf.
        set_impulse(1, 1000);
        exp_re = '{1000, 707, 0, -708, -1000, -707, 0, 708};
        exp_im = '{0, -708, -1000, -708, 0, 708, 1000, 708};
        load_frame(1'b0, 1'b0, 1'b1);
        collect_frame(1'b1);

        // Same frame as inverse.
        exp_re = '{1000, 707, 0, -708, -1000, -707, 0, 708};
        exp_im = '{0, 707, 1000, 707, 0, -707, -1000, -707};
        load_frame(1'b1, 1'b0, 1'b1);
        collect_frame(1'b1);

        // Saturation: every stage overflows on the DC path.
        set_const(20000);
        exp_re = '{32767, 0, 0, 0, 0, 0, 0, 0};
        exp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        load_frame(1'b0, 1'b0, 1'b1);
        collect_frame(1'b0);
        check_val("sat_ovf_sticky", int'(ovf), 1);

        // Next frame clears ovf at its first sample (checked inside load_frame).
        set_impulse(0, 1000);
        exp_re = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
        load_frame(1'b0, 1'b0, 1'b1);
        collect_frame(1'b0);

        // Reset during CALC aborts the frame.
        set_impulse(0, 500);
        load_frame(1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        check_val("calc_busy", int'(busy), 1);
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        check_val("abort_s_ready", int'(s_ready), 1);
        check_val("abort_m_valid", int'(m_valid), 0);
        check_val("abort_busy", int'(busy), 0);
        repeat (15) tick();
        check_val("abort_no_output", int'(m_valid), 0);

        set_impulse(0, 1000);
        load_frame(1'b0, 1'b1, 1'b1);
        collect_frame(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
